// File: rtl/perf_pkg.sv
// Shared definitions for the performance-monitor unit.
// Contents:
//   perf_state_e   - FSM state encoding (IDLE, RUN, DONE)
//   EV_*           - event-line indices for the standard pipeline events
//   DEFAULT_CNT_W  - default counter width
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    localparam int unsigned EV_STALL  = 0;
    localparam int unsigned EV_FLUSH  = 1;
    localparam int unsigned EV_RETIRE = 2;
    localparam int unsigned EV_BRANCH = 3;

    localparam int unsigned DEFAULT_CNT_W = 32;

endpackage

// File: rtl/perf_counter_unit_if.sv
// Control / read-port bundle of the performance-monitor unit.
// Signals (directions as seen by the unit, i.e. the slave modport):
//   start_i     in   level; counting enabled while high
//   clear_i     in   pulse; zero counters and flags, return to IDLE
//   event_i     in   per-cycle event strobes
//   snap_i      in   pulse; capture snapshot (snapshot builds only)
//   rd_sel_i    in   0 = cycle counter, k = event counter k-1
//   rd_data_o   out  registered read data
//   cycle_o     out  live cycle count
//   running_o   out  high in RUN
//   done_o      out  high in DONE
//   overflow_o  out  sticky per-event saturation flags
interface perf_counter_unit_if #(
    parameter int unsigned N_EVENTS = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SEL_W    = 5
);
    logic                start_i;
    logic                clear_i;
    logic [N_EVENTS-1:0] event_i;
    logic                snap_i;
    logic [SEL_W-1:0]    rd_sel_i;
    logic [CNT_W-1:0]    rd_data_o;
    logic [CNT_W-1:0]    cycle_o;
    logic                running_o;
    logic                done_o;
    logic [N_EVENTS-1:0] overflow_o;

    modport master (
        output start_i, clear_i, event_i, snap_i, rd_sel_i,
        input  rd_data_o, cycle_o, running_o, done_o, overflow_o
    );

    modport slave (
        input  start_i, clear_i, event_i, snap_i, rd_sel_i,
        output rd_data_o, cycle_o, running_o, done_o, overflow_o
    );
endinterface

// File: rtl/perf_event_counter.sv
// Saturating counter with sticky overflow flag.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous reset, active-low
//   clr_i   in   synchronous clear of count and flag (highest priority)
//   en_i    in   counting window enable
//   inc_i   in   increment request, honoured only while en_i is high
//   cnt_o   out  current count
//   ovf_o   out  set when an increment is requested while at all-ones
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i && inc_i) begin
            // Hold at all-ones; the lost increment is recorded in the flag.
            if (&cnt_q) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-monitor unit: counts run cycles and N_EVENTS pipeline event
// strobes, auto-stops after CYCLE_LIMIT run cycles (0 = never), and exposes
// every counter through a registered read port.
// Configuration macro: PERF_SNAPSHOT_EN adds shadow registers loaded by
// snap_i; reads then return the shadow values instead of the live counters.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous reset, active-low
//   bus     slave modport of perf_counter_unit_if (control, events, read port,
//           status outputs)
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int unsigned N_EVENTS    = 4,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned CYCLE_LIMIT = 64,
    parameter int unsigned SEL_W       = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    perf_counter_unit_if.slave bus
);

    // A limit above the counter's range can never be hit: the cycle counter
    // saturates first, so the unit then behaves as if the limit were 0.
    localparam logic [63:0]      CntMax     = {64{1'b1}} >> (64 - CNT_W);
    localparam bit               LimitEn    = (CYCLE_LIMIT != 0) &&
                                              (64'(CYCLE_LIMIT) <= CntMax);
    localparam logic [CNT_W-1:0] LimitPrior = CNT_W'(CYCLE_LIMIT - 1);

    perf_state_e         state_q;
    logic                running_q;
    logic                done_q;
    logic                count_en;
    logic                limit_hit;
    logic [CNT_W-1:0]    cycle_cnt;
    logic                cycle_ovf_unused;
    logic [CNT_W-1:0]    event_cnt [N_EVENTS];
    logic [N_EVENTS-1:0] event_ovf;
    logic [CNT_W-1:0]    rd_src    [N_EVENTS+1];
    logic [CNT_W-1:0]    rd_data_d;
    logic [CNT_W-1:0]    rd_data_q;

    // The edge that enters RUN already counts, so IDLE with start_i high counts.
    assign count_en  = bus.start_i && (state_q != DONE) && !bus.clear_i;
    // This edge moves the cycle count onto the limit.
    assign limit_hit = LimitEn && (cycle_cnt == LimitPrior);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.clear_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, RUN: begin
                    if (!bus.start_i) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end else if (limit_hit) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                DONE: begin
                    state_q   <= DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    perf_event_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.clear_i),
        .en_i  (count_en),
        .inc_i (1'b1),
        .cnt_o (cycle_cnt),
        .ovf_o (cycle_ovf_unused)
    );

    for (genvar k = 0; k < N_EVENTS; k++) begin : g_event
        perf_event_counter #(
            .CNT_W (CNT_W)
        ) u_event_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (bus.clear_i),
            .en_i  (count_en),
            .inc_i (bus.event_i[k]),
            .cnt_o (event_cnt[k]),
            .ovf_o (event_ovf[k])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_cycle_q;
    logic [CNT_W-1:0] shadow_event_q [N_EVENTS];

    // Shadows take the pre-edge counter values; counting runs on undisturbed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow_cycle_q <= '0;
            for (int k = 0; k < N_EVENTS; k++) shadow_event_q[k] <= '0;
        end else if (bus.clear_i) begin
            shadow_cycle_q <= '0;
            for (int k = 0; k < N_EVENTS; k++) shadow_event_q[k] <= '0;
        end else if (bus.snap_i) begin
            shadow_cycle_q <= cycle_cnt;
            for (int k = 0; k < N_EVENTS; k++) shadow_event_q[k] <= event_cnt[k];
        end
    end

    assign rd_src[0] = shadow_cycle_q;
    for (genvar k = 0; k < N_EVENTS; k++) begin : g_rd_src
        assign rd_src[k+1] = shadow_event_q[k];
    end
`else
    logic snap_unused;
    assign snap_unused = bus.snap_i;

    assign rd_src[0] = cycle_cnt;
    for (genvar k = 0; k < N_EVENTS; k++) begin : g_rd_src
        assign rd_src[k+1] = event_cnt[k];
    end
`endif

    // Selectors beyond N_EVENTS fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned k = 0; k <= N_EVENTS; k++) begin
            if (bus.rd_sel_i == SEL_W'(k)) rd_data_d = rd_src[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data_o  = rd_data_q;
    assign bus.cycle_o    = cycle_cnt;
    assign bus.running_o  = running_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = event_ovf;

endmodule
